// File: rtl/sqrt_result_reorder_buffer.sv
// sqrt_result_reorder_buffer
//   Hands out tags to in-flight square-root jobs, captures the worker
//   results out of order, and releases them strictly in allocation order.
//
// Optional feature: define SQRT_ROB_PROTOCOL_CHECK_EN to drop completions
// aimed at slots that are not PENDING and raise the sticky err flag.
// Without it, err is tied low and every completion is accepted.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   alloc_vld  request a tag for a new job
//   alloc_rdy  a free slot exists
//   alloc_tag  tag granted on alloc_vld && alloc_rdy
//   res_vld    worker completion presented this cycle
//   res_tag    tag of the completion
//   res        result value of the completion
//   out_vld    head result available
//   out_rdy    downstream accepts the head result
//   out_res    head result value
//   out_tag    head tag
//   count      allocated, not yet retired slots
//   err        sticky protocol-error flag
module sqrt_result_reorder_buffer #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 32,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_vld,
  output logic              alloc_rdy,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              res_vld,
  input  logic [TAG_W-1:0]  res_tag,
  input  logic [DATA_W-1:0] res,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_res,
  output logic [TAG_W-1:0]  out_tag,
  output logic [TAG_W:0]    count,
  output logic              err
);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_e;

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  slot_e             r_state     [DEPTH];
  slot_e             w_state_nxt [DEPTH];
  logic [DATA_W-1:0] r_data      [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic w_alloc;
  logic w_retire;
  logic w_res_ok;

  assign alloc_rdy = (r_count != FULL_CNT);
  assign alloc_tag = r_tail;
  // Head is DONE only if it was allocated, so out_vld is 0 whenever count is 0.
  assign out_vld   = (r_state[r_head] == SLOT_DONE);
  assign out_res   = r_data[r_head];
  assign out_tag   = r_head;
  assign count     = r_count;

  assign w_alloc  = alloc_vld && alloc_rdy;
  assign w_retire = out_vld && out_rdy;

`ifdef SQRT_ROB_PROTOCOL_CHECK_EN
  logic r_err;

  assign w_res_ok = res_vld && (r_state[res_tag] == SLOT_PENDING);
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (res_vld && !w_res_ok) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_res_ok = res_vld;
  assign err      = 1'b0;
`endif

  // Alloc, completion and retire target different slots in legal traffic;
  // for unchecked collisions the later assignment (retire last) wins.
  always_comb begin
    w_state_nxt = r_state;
    if (w_alloc) begin
      w_state_nxt[r_tail] = SLOT_PENDING;
    end
    if (w_res_ok) begin
      w_state_nxt[res_tag] = SLOT_DONE;
    end
    if (w_retire) begin
      w_state_nxt[r_head] = SLOT_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_state[i] <= SLOT_FREE;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_alloc) begin
        r_tail <= r_tail + TAG_ONE;
      end
      if (w_retire) begin
        r_head <= r_head + TAG_ONE;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Result storage carries no reset; only slot state qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && w_res_ok) begin
      r_data[res_tag] <= res;
    end
  end

endmodule

// File: tb/tb_sqrt_result_reorder_buffer.sv
module tb_sqrt_result_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_vld;
  logic              alloc_rdy;
  logic [TAG_W-1:0]  alloc_tag;
  logic              res_vld;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res;
  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_res;
  logic [TAG_W-1:0]  out_tag;
  logic [TAG_W:0]    count;
  logic              err;

  sqrt_result_reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
    .res_vld(res_vld), .res_tag(res_tag), .res(res),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res), .out_tag(out_tag),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tags in allocation order, plus per-tag done flag and data.
  int unsigned       m_q[$];
  bit                m_done [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  int unsigned       m_tail = 0;
  bit                m_err  = 0;
  int unsigned       m_nret = 0;
  bit                ma, mr, mc;

  function automatic bit m_pending(input int unsigned t);
    foreach (m_q[i]) if (m_q[i] == t) return !m_done[t];
    return 0;
  endfunction

  function automatic bit m_out_vld();
    return (m_q.size() != 0) && m_done[m_q[0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      foreach (m_done[i]) m_done[i] = 0;
      m_tail = 0;
      m_err  = 0;
    end else begin
      ma = alloc_vld && (m_q.size() != DEPTH);
      mr = out_rdy && m_out_vld();
`ifdef SQRT_ROB_PROTOCOL_CHECK_EN
      mc = res_vld && m_pending(res_tag);
      if (res_vld && !mc) m_err = 1;
`else
      mc = res_vld;
`endif
      if (mr) begin
        m_done[m_q[0]] = 0;
        void'(m_q.pop_front());
        m_nret++;
      end
      if (mc) begin
        m_done[res_tag] = 1;
        m_data[res_tag] = res;
      end
      if (ma) begin
        m_q.push_back(m_tail);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("alloc_rdy", alloc_rdy, m_q.size() != DEPTH);
      check("alloc_tag", alloc_tag, m_tail);
      check("count", count, m_q.size());
      check("out_vld", out_vld, m_out_vld());
      check("err", err, m_err);
      if (m_out_vld()) begin
        check("out_tag", out_tag, m_q[0]);
        check("out_res", out_res, m_data[m_q[0]]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_vld = 0; res_vld = 0; res_tag = '0; res = '0; out_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  function automatic int pick_pending();
    int unsigned lst[$];
    foreach (m_q[i]) if (!m_done[m_q[i]]) lst.push_back(m_q[i]);
    if (lst.size() == 0) return -1;
    return int'(lst[$urandom_range(lst.size() - 1)]);
  endfunction

  typedef struct {
    int unsigned       due;
    int unsigned       tag;
    logic [DATA_W-1:0] val;
  } sched_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg[3];
    int vl[3];
    int ev[3];
    int k;
    sched_t sq[$];
    int unsigned now;
    int unsigned base;
    int p;

    rst = 1;
    idle();
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // Reset values
    check("rst_out_vld", out_vld, 0);
    check("rst_alloc_rdy", alloc_rdy, 1);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);

    // Three allocs, completions 2,0,1 -> release 10,20,30 in tag order
    tg = '{2, 0, 1};
    vl = '{30, 10, 20};
    ev = '{10, 20, 30};
    alloc_vld = 1;
    repeat (3) tick();
    alloc_vld = 0;
    check("ooo_count3", count, 3);
    out_rdy = 1;
    k = 0;
    for (int cy = 0; cy < 10; cy++) begin
      res_vld = (cy < 3);
      if (cy < 3) begin
        res_tag = TAG_W'(tg[cy]);
        res     = DATA_W'(vl[cy]);
      end
      tick();
      if (out_vld) begin
        if (k < 3) begin
          check("ooo_res", out_res, ev[k]);
          check("ooo_tag", out_tag, k);
        end
        k++;
      end
    end
    res_vld = 0;
    check("ooo_nret", k, 3);
    check("ooo_count0", count, 0);

    // Completion latency on the head slot
    alloc_vld = 1;
    tick();
    alloc_vld = 0;
    check("lat_pre_vld", out_vld, 0);
    res_vld = 1; res_tag = TAG_W'(3); res = 77;
    tick();
    res_vld = 0;
    check("lat_vld", out_vld, 1);
    check("lat_res", out_res, 77);
    check("lat_tag", out_tag, 3);
    tick();
    check("lat_retired_vld", out_vld, 0);
    check("lat_retired_cnt", count, 0);

    // Fill from reset, then free tag 0
    do_reset();
    alloc_vld = 1;
    out_rdy   = 1;
    repeat (18) tick();
    check("full_rdy", alloc_rdy, 0);
    check("full_count", count, 16);
    alloc_vld = 0;
    res_vld = 1; res_tag = '0; res = 5;
    tick();
    res_vld = 0;
    check("full_head_vld", out_vld, 1);
    tick();
    check("full_rdy_back", alloc_rdy, 1);
    check("full_next_tag", alloc_tag, 0);
    check("full_count15", count, 15);

    // Back-pressure hold, then one retire per cycle
    out_rdy = 0;
    for (int t = 1; t <= 4; t++) begin
      res_vld = 1; res_tag = TAG_W'(t); res = DATA_W'(100 + t);
      tick();
    end
    res_vld = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("hold_vld", out_vld, 1);
      check("hold_res", out_res, 101);
      check("hold_tag", out_tag, 1);
      check("hold_count", count, 15);
    end
    out_rdy = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("drain_count", count, 14 - j);
      if (j < 3) check("drain_tag", out_tag, 2 + j);
      else check("drain_vld_end", out_vld, 0);
    end

    // Continuous alloc, fixed 50-cycle completion latency, 200 results
    do_reset();
    out_rdy = 1;
    base = m_nret;
    now = 0;
    k = 0;
    while ((m_nret - base) < 200 && now < 3000) begin
      alloc_vld = (k < 200);
      if (alloc_vld && m_q.size() != DEPTH) begin
        sq.push_back('{now + 50, m_tail, DATA_W'($urandom)});
        k++;
      end
      res_vld = 0;
      if (sq.size() != 0 && sq[0].due <= now) begin
        res_vld = 1;
        res_tag = TAG_W'(sq[0].tag);
        res     = sq[0].val;
        void'(sq.pop_front());
      end
      tick();
      now++;
    end
    idle();
    check("stream_nret", m_nret - base, 200);
    check("stream_count0", count, 0);

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int cy = 0; cy < 800; cy++) begin
      rst       = (cy == 400);
      alloc_vld = ($urandom_range(3) != 0);
      out_rdy   = ($urandom_range(2) != 0);
      res       = DATA_W'($urandom);
      p = pick_pending();
      res_vld = (p >= 0) && ($urandom_range(1) == 1);
      res_tag = (p >= 0) ? TAG_W'(p) : '0;
`ifdef SQRT_ROB_PROTOCOL_CHECK_EN
      if (cy > 600 && $urandom_range(39) == 0) begin
        res_vld = 1;
        res_tag = TAG_W'($urandom);
      end
`endif
      tick();
    end
    rst = 0;
    idle();

`ifdef SQRT_ROB_PROTOCOL_CHECK_EN
    // Completion to a FREE tag raises err and changes nothing else
    do_reset();
    res_vld = 1; res_tag = TAG_W'(5); res = 1;
    tick();
    res_vld = 0;
    check("perr_err", err, 1);
    check("perr_count", count, 0);
    check("perr_vld", out_vld, 0);
    rst = 1;
    tick();
    rst = 0;
    check("perr_cleared", err, 0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
